// File: rtl/esop_cube_stream_eval_if.sv
// Cube stream handshake between a cube source (ROM, host loader) and the ESOP evaluator.
interface esop_cube_stream_eval_if #(
    parameter int unsigned NUM_VARS = 50
) ();
    logic                cube_valid;
    logic                cube_ready;
    logic [NUM_VARS-1:0] cube_mask;
    logic [NUM_VARS-1:0] cube_pol;
    logic                cube_last;

    modport master (
        output cube_valid,
        output cube_mask,
        output cube_pol,
        output cube_last,
        input  cube_ready
    );

    modport slave (
        input  cube_valid,
        input  cube_mask,
        input  cube_pol,
        input  cube_last,
        output cube_ready
    );
endinterface

// File: rtl/esop_cube_stream_eval.sv
// Streaming ESOP evaluator: XOR-accumulates cube hits against a latched input assignment.
module esop_cube_stream_eval #(
    parameter int unsigned NUM_VARS = 50,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_VARS-1:0]     x_in,
    esop_cube_stream_eval_if.slave  cube,
    output logic                    res_valid,
    output logic                    res_o,
    output logic [CNT_W-1:0]        res_cubes,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_VARS-1:0] x_q;
    logic                acc;
    logic [CNT_W-1:0]    cnt;

    logic                hit_c;
    logic                accept_c;
    logic                acc_next_c;
    logic [CNT_W-1:0]    cnt_next_c;

    // A cube hits when every literal it contains agrees with the latched assignment.
    assign hit_c      = &(~cube.cube_mask | ~(x_q ^ cube.cube_pol));
    assign accept_c   = cube.cube_valid & cube.cube_ready;
    assign acc_next_c = acc ^ hit_c;
    assign cnt_next_c = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Results are loaded on the final accepted beat so they line up with the DONE pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            x_q             <= '0;
            acc             <= 1'b0;
            cnt             <= '0;
            cube.cube_ready <= 1'b0;
            res_valid       <= 1'b0;
            res_o           <= 1'b0;
            res_cubes       <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q             <= x_in;
                        acc             <= 1'b0;
                        cnt             <= '0;
                        state           <= RUN;
                        cube.cube_ready <= 1'b1;
                        busy            <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        acc <= acc_next_c;
                        cnt <= cnt_next_c;
                        if (cube.cube_last) begin
                            state           <= DONE;
                            cube.cube_ready <= 1'b0;
                            res_valid       <= 1'b1;
                            res_o           <= acc_next_c;
                            res_cubes       <= cnt_next_c;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    cube.cube_ready <= 1'b0;
                    res_valid       <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esop_cube_stream_eval.sv
// Directed bench for esop_cube_stream_eval: vector table plus multi-cycle corner sequences.
module tb_esop_cube_stream_eval;

    localparam int unsigned NV   = 50;
    localparam int unsigned CW   = 16;
    localparam int unsigned SNV  = 4;
    localparam int unsigned SCW  = 2;
    localparam int unsigned NVEC = 6;

    logic clk;
    logic rst_n;

    logic            start;
    logic [NV-1:0]   x_in;
    logic            res_valid;
    logic            res_o;
    logic [CW-1:0]   res_cubes;
    logic            busy;

    logic            s_start;
    logic [SNV-1:0]  s_x_in;
    logic            s_res_valid;
    logic            s_res_o;
    logic [SCW-1:0]  s_res_cubes;
    logic            s_busy;

    esop_cube_stream_eval_if #(.NUM_VARS(NV))  cif ();
    esop_cube_stream_eval_if #(.NUM_VARS(SNV)) sif ();

    esop_cube_stream_eval #(.NUM_VARS(NV), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .cube      (cif.slave),
        .res_valid (res_valid),
        .res_o     (res_o),
        .res_cubes (res_cubes),
        .busy      (busy)
    );

    esop_cube_stream_eval #(.NUM_VARS(SNV), .CNT_W(SCW)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .x_in      (s_x_in),
        .cube      (sif.slave),
        .res_valid (s_res_valid),
        .res_o     (s_res_o),
        .res_cubes (s_res_cubes),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string               name;
        logic [NV-1:0]       x;
        int                  n;
        logic [2:0][NV-1:0]  mask;
        logic [2:0][NV-1:0]  pol;
        logic                exp_o;
        logic [CW-1:0]       exp_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    int tests;
    int failed;
    logic          held_o;
    logic [CW-1:0] held_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_cube();
        cif.cube_valid = 1'b0;
        cif.cube_mask  = '0;
        cif.cube_pol   = '0;
        cif.cube_last  = 1'b0;
    endtask

    task automatic do_start(input logic [NV-1:0] x);
        start = 1'b1;
        x_in  = x;
        @(negedge clk);
        start = 1'b0;
        x_in  = ~x;
    endtask

    task automatic run_vec(input vec_t v);
        do_start(v.x);
        check({v.name, " ready"}, 64'(cif.cube_ready), 64'd1);
        check({v.name, " busy"},  64'(busy), 64'd1);
        check({v.name, " res_o held"}, 64'(res_o), 64'(held_o));
        check({v.name, " res_cubes held"}, 64'(res_cubes), 64'(held_cnt));
        for (int i = 0; i < v.n; i++) begin
            cif.cube_valid = 1'b1;
            cif.cube_mask  = v.mask[i];
            cif.cube_pol   = v.pol[i];
            cif.cube_last  = (i == v.n - 1);
            @(negedge clk);
            if (i != v.n - 1) check({v.name, " early res_valid"}, 64'(res_valid), 64'd0);
        end
        idle_cube();
        check({v.name, " res_valid"}, 64'(res_valid), 64'd1);
        check({v.name, " res_o"}, 64'(res_o), 64'(v.exp_o));
        check({v.name, " res_cubes"}, 64'(res_cubes), 64'(v.exp_cnt));
        @(negedge clk);
        check({v.name, " res_valid drop"}, 64'(res_valid), 64'd0);
        check({v.name, " busy drop"}, 64'(busy), 64'd0);
        held_o   = v.exp_o;
        held_cnt = v.exp_cnt;
    endtask

    initial begin
        logic [NV-1:0] b16;
        logic [NV-1:0] b48;
        int vpat [6];
        tests    = 0;
        failed   = 0;
        held_o   = 1'b0;
        held_cnt = '0;
        b16 = '0; b16[16] = 1'b1;
        b48 = '0; b48[48] = 1'b1;

        vecs[0] = '{"const1", '0, 1, '{default: '0}, '{default: '0}, 1'b1, 16'd1};
        vecs[1] = '{"two_hits", b16, 2, '{default: '0}, '{default: '0}, 1'b0, 16'd2};
        vecs[1].mask[0] = b16; vecs[1].pol[0] = b16;
        vecs[1].mask[1] = b48; vecs[1].pol[1] = '0;
        vecs[2] = '{"cubeA_pos", b16, 1, '{default: '0}, '{default: '0}, 1'b1, 16'd1};
        vecs[2].mask[0] = b16; vecs[2].pol[0] = b16;
        vecs[3] = '{"cubeA_neg", b16, 1, '{default: '0}, '{default: '0}, 1'b0, 16'd1};
        vecs[3].mask[0] = b16; vecs[3].pol[0] = '0;
        vecs[4] = '{"ones_mix", '1, 3, '{default: '0}, '{default: '0}, 1'b0, 16'd3};
        vecs[4].mask[0] = '1;         vecs[4].pol[0] = '1;
        vecs[4].mask[1] = NV'(1);     vecs[4].pol[1] = '0;
        vecs[4].mask[2] = (NV'(1) << 49) | NV'(2);
        vecs[4].pol[2]  = (NV'(1) << 49) | NV'(2);
        vecs[5] = '{"three_hits", NV'(5), 3, '{default: '0}, '{default: '0}, 1'b1, 16'd3};
        vecs[5].mask[0] = NV'(7); vecs[5].pol[0] = NV'(5);
        vecs[5].mask[1] = NV'(2); vecs[5].pol[1] = '0;

        rst_n   = 1'b0;
        start   = 1'b0;
        x_in    = '0;
        s_start = 1'b0;
        s_x_in  = '0;
        idle_cube();
        sif.cube_valid = 1'b0;
        sif.cube_mask  = '0;
        sif.cube_pol   = '0;
        sif.cube_last  = 1'b0;
        repeat (2) @(negedge clk);

        check("reset ready",     64'(cif.cube_ready), 64'd0);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset res_o",     64'(res_o), 64'd0);
        check("reset res_cubes", 64'(res_cubes), 64'd0);
        check("reset busy",      64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < int'(NVEC); k++) begin
            run_vec(vecs[k]);
            @(negedge clk);
        end

        // Backpressure: valid 1,0,0,1,0,1 with last on the third valid beat.
        vpat = '{1, 0, 0, 1, 0, 1};
        do_start('0);
        for (int i = 0; i < 6; i++) begin
            cif.cube_valid = vpat[i][0];
            cif.cube_last  = (i == 5) || (i == 2) || (i == 4);
            @(negedge clk);
            if (i != 5) check("bp no early res_valid", 64'(res_valid), 64'd0);
        end
        idle_cube();
        check("bp res_valid", 64'(res_valid), 64'd1);
        check("bp res_o", 64'(res_o), 64'd1);
        check("bp res_cubes", 64'(res_cubes), 64'd3);
        @(negedge clk);
        check("bp res_valid single", 64'(res_valid), 64'd0);
        @(negedge clk);

        // start pulsed during RUN with a different assignment must be ignored.
        do_start(b16);
        start = 1'b1;
        x_in  = '0;
        @(negedge clk);
        start = 1'b0;
        cif.cube_valid = 1'b1;
        cif.cube_mask  = b16;
        cif.cube_pol   = b16;
        cif.cube_last  = 1'b1;
        @(negedge clk);
        idle_cube();
        check("ign_start res_valid", 64'(res_valid), 64'd1);
        check("ign_start res_o", 64'(res_o), 64'd1);
        check("ign_start res_cubes", 64'(res_cubes), 64'd1);
        repeat (2) @(negedge clk);

        // Reset after two accepted cubes discards the list.
        do_start('0);
        cif.cube_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst ready", 64'(cif.cube_ready), 64'd0);
        check("mid_rst busy",  64'(busy), 64'd0);
        check("mid_rst res_o", 64'(res_o), 64'd0);
        check("mid_rst res_cubes", 64'(res_cubes), 64'd0);
        check("mid_rst res_valid", 64'(res_valid), 64'd0);
        idle_cube();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst no res_valid", 64'(res_valid), 64'd0);
        end
        held_o   = 1'b0;
        held_cnt = '0;
        run_vec(vecs[1]);
        @(negedge clk);
        run_vec(vecs[5]);

        // Saturating counter on the narrow instance: five constant-1 cubes.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sif.cube_valid = 1'b1;
            sif.cube_last  = (i == 4);
            @(negedge clk);
        end
        sif.cube_valid = 1'b0;
        sif.cube_last  = 1'b0;
        check("sat res_valid", 64'(s_res_valid), 64'd1);
        check("sat res_cubes", 64'(s_res_cubes), 64'd3);
        check("sat res_o", 64'(s_res_o), 64'd1);
        @(negedge clk);
        check("sat busy drop", 64'(s_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
